// File: rtl/rob_multiport_pkg.sv
// Shared types and default sizes for the multi-port reorder buffer.
//   opcode_t       : instruction opcodes; STORE is flagged on retire
//   rob_entry_t    : what rename/dispatch hands to the ROB per lane
//   rob_retire_t   : the subset of an entry that commit consumes
//   to_retire()    : converts a dispatched entry into its retire record
package rob_multiport_pkg;

    localparam int NUM_ENTRY_DEF      = 16;
    localparam int PHY_WIDTH          = 6;
    localparam int DISPATCH_WIDTH_DEF = 2;
    localparam int NUM_WB_DEF         = 3;
    localparam int RETIRE_WIDTH_DEF   = 2;

    typedef enum logic [3:0] {
        OP_ALU    = 4'd0,
        OP_LOAD   = 4'd1,
        OP_STORE  = 4'd2,
        OP_BRANCH = 4'd3,
        OP_JUMP   = 4'd4
    } opcode_t;

    typedef struct packed {
        logic [4:0]           rd_arch;
        logic [PHY_WIDTH-1:0] rd_phy_old;
        logic [PHY_WIDTH-1:0] rd_phy_new;
        opcode_t              opcode;
        logic [31:0]          pred_target;
        logic                 pred_taken;
    } rob_entry_t;

    typedef struct packed {
        logic [4:0]           rd_arch;
        logic [PHY_WIDTH-1:0] rd_phy_old;
        logic [PHY_WIDTH-1:0] rd_phy_new;
        logic                 is_store;
    } rob_retire_t;

    // Prediction fields are resolved at writeback, so only the commit-side
    // fields need to live in the entry storage.
    function automatic rob_retire_t to_retire(input rob_entry_t e);
        rob_retire_t r;
        r.rd_arch    = e.rd_arch;
        r.rd_phy_old = e.rd_phy_old;
        r.rd_phy_new = e.rd_phy_new;
        r.is_store   = (e.opcode == OP_STORE);
        return r;
    endfunction

endpackage

// File: rtl/rob_multiport_if.sv
// Dispatch / writeback / retire / status bundle of the reorder buffer.
//   master : frontend + execution side (drives dispatch and writeback)
//   slave  : the ROB (drives ready, ids, retire lanes, flush and status)
interface rob_multiport_if
    import rob_multiport_pkg::*;
#(
    parameter int NUM_ENTRY      = NUM_ENTRY_DEF,
    parameter int DISPATCH_WIDTH = DISPATCH_WIDTH_DEF,
    parameter int NUM_WB         = NUM_WB_DEF,
    parameter int RETIRE_WIDTH   = RETIRE_WIDTH_DEF
) ();
    localparam int ROB_WIDTH = $clog2(NUM_ENTRY);

    // dispatch
    logic [DISPATCH_WIDTH-1:0]                dispatch_valid;
    rob_entry_t [DISPATCH_WIDTH-1:0]          dispatch_entry;
    logic                                     dispatch_ready;
    logic [DISPATCH_WIDTH-1:0][ROB_WIDTH-1:0] dispatch_rob_id;
    // writeback
    logic [NUM_WB-1:0]                        wb_valid;
    logic [NUM_WB-1:0][ROB_WIDTH-1:0]         wb_rob_id;
    logic [NUM_WB-1:0]                        wb_mispredict;
    logic [NUM_WB-1:0][31:0]                  wb_actual_target;
    // retire
    logic [RETIRE_WIDTH-1:0]                  retire_valid;
    logic [RETIRE_WIDTH-1:0]                  retire_is_store;
    logic [RETIRE_WIDTH-1:0][4:0]             retire_rd_arch;
    logic [RETIRE_WIDTH-1:0][PHY_WIDTH-1:0]   retire_rd_phy_old;
    logic [RETIRE_WIDTH-1:0][PHY_WIDTH-1:0]   retire_rd_phy_new;
    // flush and status
    logic                                     flush_valid;
    logic [31:0]                              flush_target;
    logic [ROB_WIDTH:0]                       count;
    logic                                     full;
    logic                                     empty;

    modport master (
        output dispatch_valid, dispatch_entry,
        input  dispatch_ready, dispatch_rob_id,
        output wb_valid, wb_rob_id, wb_mispredict, wb_actual_target,
        input  retire_valid, retire_is_store, retire_rd_arch,
        input  retire_rd_phy_old, retire_rd_phy_new,
        input  flush_valid, flush_target, count, full, empty
    );

    modport slave (
        input  dispatch_valid, dispatch_entry,
        output dispatch_ready, dispatch_rob_id,
        input  wb_valid, wb_rob_id, wb_mispredict, wb_actual_target,
        output retire_valid, retire_is_store, retire_rd_arch,
        output retire_rd_phy_old, retire_rd_phy_new,
        output flush_valid, flush_target, count, full, empty
    );

endinterface

// File: rtl/rob_retire_select.sv
// Combinational retire scan. Starting at head, walks up to RETIRE_WIDTH
// consecutive occupied entries while they are finished. A mispredicted
// entry retires but ends the scan and raises flush.
//   head, count        : ROB head pointer and occupancy
//   finish, mispredict : per-entry status bits
//   retire_cnt         : number of entries retiring this cycle
//   retire_idx         : ROB index examined by each lane (head + lane)
//   flush, flush_idx   : a mispredicted entry retires, and which one
module rob_retire_select #(
    parameter int NUM_ENTRY    = 16,
    parameter int RETIRE_WIDTH = 2,
    localparam int ROB_WIDTH   = $clog2(NUM_ENTRY),
    localparam int CNT_W       = ROB_WIDTH + 1,
    localparam int RET_CNT_W   = $clog2(RETIRE_WIDTH + 1)
) (
    input  logic [ROB_WIDTH-1:0] head,
    input  logic [CNT_W-1:0]     count,
    input  logic [NUM_ENTRY-1:0] finish,
    input  logic [NUM_ENTRY-1:0] mispredict,
    output logic [RET_CNT_W-1:0] retire_cnt,
    output logic [ROB_WIDTH-1:0] retire_idx [RETIRE_WIDTH],
    output logic                 flush,
    output logic [ROB_WIDTH-1:0] flush_idx
);

    // NUM_ENTRY is a power of two, so the natural pointer wrap is the modulo.
    generate
        for (genvar gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_idx
            assign retire_idx[gi] = head + ROB_WIDTH'(gi);
        end
    endgenerate

    logic scanning;

    always_comb begin
        retire_cnt = '0;
        flush      = 1'b0;
        flush_idx  = '0;
        scanning   = 1'b1;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (scanning && (CNT_W'(i) < count) && finish[retire_idx[i]]) begin
                retire_cnt = retire_cnt + RET_CNT_W'(1);
                if (mispredict[retire_idx[i]]) begin
                    flush     = 1'b1;
                    flush_idx = retire_idx[i];
                    scanning  = 1'b0;
                end
            end else begin
                scanning = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// In-order-retire reorder buffer with N-wide dispatch, M writeback ports,
// R-wide retire and branch-mispredict flush of all younger entries.
//   clk, rst : clock, synchronous active-high reset
//   rob      : slave side of rob_multiport_if (dispatch, writeback, retire,
//              flush, count/full/empty)
// The physical register width is fixed by rob_multiport_pkg::PHY_WIDTH,
// since the entry struct carries it.
module rob_multiport
    import rob_multiport_pkg::*;
#(
    parameter int NUM_ENTRY      = NUM_ENTRY_DEF,
    parameter int DISPATCH_WIDTH = DISPATCH_WIDTH_DEF,
    parameter int NUM_WB         = NUM_WB_DEF,
    parameter int RETIRE_WIDTH   = RETIRE_WIDTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    rob_multiport_if.slave rob
);
    localparam int ROB_WIDTH  = $clog2(NUM_ENTRY);
    localparam int CNT_W      = ROB_WIDTH + 1;
    localparam int DISP_CNT_W = $clog2(DISPATCH_WIDTH + 1);
    localparam int RET_CNT_W  = $clog2(RETIRE_WIDTH + 1);

    // state
    logic [ROB_WIDTH-1:0]    head_reg, tail_reg;
    logic [CNT_W-1:0]        count_reg;
    logic [NUM_ENTRY-1:0]    finish_reg, mispredict_reg;
    logic [NUM_ENTRY-1:0]    finish_next, mispredict_next;
    logic                    flush_valid_reg;
    logic [31:0]             flush_target_reg;
    logic [RETIRE_WIDTH-1:0] ret_valid_reg;
    rob_retire_t [RETIRE_WIDTH-1:0] ret_data_reg;

    // entry storage, no reset needed: validity lives in count/finish
    rob_retire_t info_mem   [NUM_ENTRY];
    logic [31:0] target_mem [NUM_ENTRY];

    // ---------------- dispatch ----------------
    logic [DISPATCH_WIDTH-1:0][ROB_WIDTH-1:0] disp_id;
    logic [DISP_CNT_W-1:0] disp_cnt;
    logic                  disp_ready, disp_fire;

    // Valid lanes are packed onto consecutive slots starting at tail.
    always_comb begin
        disp_cnt = '0;
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            disp_id[l] = '0;
            if (rob.dispatch_valid[l]) begin
                disp_id[l] = tail_reg + ROB_WIDTH'(disp_cnt);
                disp_cnt   = disp_cnt + DISP_CNT_W'(1);
            end
        end
    end

    // Registered state only: slots freed by this cycle's retire are not
    // offered until the next cycle.
    assign disp_ready = ((CNT_W'(NUM_ENTRY) - count_reg) >= CNT_W'(DISPATCH_WIDTH))
                        && !flush_valid_reg;

    // ---------------- retire select ----------------
    logic [RET_CNT_W-1:0] sel_cnt;
    logic [ROB_WIDTH-1:0] sel_idx [RETIRE_WIDTH];
    logic                 sel_flush;
    logic [ROB_WIDTH-1:0] sel_flush_idx;

    rob_retire_select #(
        .NUM_ENTRY    (NUM_ENTRY),
        .RETIRE_WIDTH (RETIRE_WIDTH)
    ) u_select (
        .head       (head_reg),
        .count      (count_reg),
        .finish     (finish_reg),
        .mispredict (mispredict_reg),
        .retire_cnt (sel_cnt),
        .retire_idx (sel_idx),
        .flush      (sel_flush),
        .flush_idx  (sel_flush_idx)
    );

    // Dispatches landing on the flush edge belong to the killed path.
    assign disp_fire = disp_ready && (|rob.dispatch_valid) && !sel_flush;

    logic        ret_valid_next [RETIRE_WIDTH];
    rob_retire_t ret_data_next  [RETIRE_WIDTH];

    generate
        for (genvar gi = 0; gi < RETIRE_WIDTH; gi++) begin : g_ret
            assign ret_valid_next[gi] = (RET_CNT_W'(gi) < sel_cnt);
            assign ret_data_next[gi]  = ret_valid_next[gi] ? info_mem[sel_idx[gi]] : '0;
        end
    endgenerate

    // Writebacks arriving while the flush pulse is out are from the killed path.
    logic [NUM_WB-1:0] wb_en;
    assign wb_en = rob.wb_valid & {NUM_WB{!flush_valid_reg}};

    // ---------------- status bit update ----------------
    always_comb begin
        finish_next     = finish_reg;
        mispredict_next = mispredict_reg;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (ret_valid_next[i]) begin
                finish_next[sel_idx[i]]     = 1'b0;
                mispredict_next[sel_idx[i]] = 1'b0;
            end
        end
        for (int w = 0; w < NUM_WB; w++) begin
            if (wb_en[w]) begin
                finish_next[rob.wb_rob_id[w]]     = 1'b1;
                mispredict_next[rob.wb_rob_id[w]] = rob.wb_mispredict[w];
            end
        end
        if (disp_fire) begin
            for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                if (rob.dispatch_valid[l]) begin
                    finish_next[disp_id[l]]     = 1'b0;
                    mispredict_next[disp_id[l]] = 1'b0;
                end
            end
        end
        if (sel_flush) begin
            finish_next     = '0;
            mispredict_next = '0;
        end
    end

    logic [ROB_WIDTH-1:0] head_next;
    logic [CNT_W-1:0]     disp_add;
    assign head_next = head_reg + ROB_WIDTH'(sel_cnt);
    assign disp_add  = disp_fire ? CNT_W'(disp_cnt) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            finish_reg       <= '0;
            mispredict_reg   <= '0;
            flush_valid_reg  <= 1'b0;
            flush_target_reg <= '0;
            ret_valid_reg    <= '0;
            ret_data_reg     <= '0;
        end else begin
            head_reg         <= head_next;
            finish_reg       <= finish_next;
            mispredict_reg   <= mispredict_next;
            flush_valid_reg  <= sel_flush;
            flush_target_reg <= sel_flush ? target_mem[sel_flush_idx] : 32'd0;
            for (int i = 0; i < RETIRE_WIDTH; i++) begin
                ret_valid_reg[i] <= ret_valid_next[i];
                ret_data_reg[i]  <= ret_data_next[i];
            end
            if (sel_flush) begin
                // Everything younger than the mispredicted entry is squashed.
                tail_reg  <= head_next;
                count_reg <= '0;
            end else begin
                tail_reg  <= tail_reg + ROB_WIDTH'(disp_add);
                count_reg <= count_reg + disp_add - CNT_W'(sel_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            if (disp_fire && rob.dispatch_valid[l]) begin
                info_mem[disp_id[l]] <= to_retire(rob.dispatch_entry[l]);
            end
        end
        for (int w = 0; w < NUM_WB; w++) begin
            if (wb_en[w]) begin
                target_mem[rob.wb_rob_id[w]] <= rob.wb_actual_target[w];
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        rob.retire_is_store   = '0;
        rob.retire_rd_arch    = '0;
        rob.retire_rd_phy_old = '0;
        rob.retire_rd_phy_new = '0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            rob.retire_is_store[i]   = ret_data_reg[i].is_store;
            rob.retire_rd_arch[i]    = ret_data_reg[i].rd_arch;
            rob.retire_rd_phy_old[i] = ret_data_reg[i].rd_phy_old;
            rob.retire_rd_phy_new[i] = ret_data_reg[i].rd_phy_new;
        end
    end

    assign rob.dispatch_ready  = disp_ready;
    assign rob.dispatch_rob_id = disp_id;
    assign rob.retire_valid    = ret_valid_reg;
    assign rob.flush_valid     = flush_valid_reg;
    assign rob.flush_target    = flush_target_reg;
    assign rob.count           = count_reg;
    assign rob.full            = (count_reg == CNT_W'(NUM_ENTRY));
    assign rob.empty           = (count_reg == '0);

endmodule
